muladdmem_win: RTL and testbench

Parametrised windowed multiply-accumulate engine with integrated weight memory; next generation of the single-tap multiply-add memory block. Weights are written into an internal 2^ADDR_W-entry register file, then a start pulse runs a TAPS-long dot product against a handshaked pixel stream. Each result is rounded, saturated and returned through a valid/ready output port. The block is one convolution-window unit of the CNN datapath.

---
 rtl/muladdmem_win.sv | 130 +++++++++++++
 tb/tb_muladdmem_win.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/muladdmem_win.sv
// Windowed multiply-accumulate unit with an internal weight register file.
// Optional fused ReLU on the rounded result when MULADD_RELU_EN is defined.
module muladdmem_win #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5,
   parameter int TAPS   = 9,
   parameter int FRAC_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] dataIn,
   input  logic [ADDR_W-1:0] base,
   input  logic              start,
   input  logic              pix_valid,
   input  logic [DATA_W-1:0] pix_in,
   output logic              pix_ready,
   output logic [DATA_W-1:0] out_pix,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   localparam int ACC_W = 2*DATA_W + $clog2(TAPS);
   localparam int PW    = 2*DATA_W;
   localparam int CNT_W = $clog2(TAPS+1);
   localparam logic signed [ACC_W-1:0] RND     = ACC_W'(64'd1 << (FRAC_W-1));
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << (DATA_W-1)) - 64'd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

   typedef enum logic [1:0] {IDLE, MAC, ROUND, DONE} state_t;

   state_t                    state_q, state_d;
   logic        [ADDR_W-1:0]  ptr_q, ptr_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic        [CNT_W-1:0]   cnt_q, cnt_d;
   logic        [DATA_W-1:0]  outPix_q, outPix_d;
   logic                      outValid_q, outValid_d;

   logic signed [DATA_W-1:0]  wmem_q [2**ADDR_W];
   logic signed [DATA_W-1:0]  wmemRd;
   logic signed [PW-1:0]      pixExt, wExt, prod;
   logic signed [ACC_W-1:0]   prodExt, rounded;
   logic        [DATA_W-1:0]  satPix;

   // Weight memory has no reset so loaded weights survive an aborted window.
   always_ff @(posedge clk) begin
      if (we) wmem_q[addr] <= dataIn;
   end

   assign wmemRd  = wmem_q[ptr_q];
   assign pixExt  = PW'($signed(pix_in));
   assign wExt    = PW'(wmemRd);
   assign prod    = pixExt * wExt;
   assign prodExt = ACC_W'(prod);
   assign rounded = (acc_q + RND) >>> FRAC_W;

   always_comb begin
      satPix = rounded[DATA_W-1:0];
      if (rounded > SAT_MAX)      satPix = {1'b0, {(DATA_W-1){1'b1}}};
      else if (rounded < SAT_MIN) satPix = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef MULADD_RELU_EN
      if (satPix[DATA_W-1]) satPix = '0;
`endif
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      outPix_d   = outPix_q;
      outValid_d = outValid_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               ptr_d   = base;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            if (pix_valid) begin
               acc_d = acc_q + prodExt;
               ptr_d = ptr_q + ADDR_W'(1);
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(TAPS-1)) state_d = ROUND;
            end
         end
         ROUND: begin
            outPix_d   = satPix;
            outValid_d = 1'b1;
            state_d    = DONE;
         end
         DONE: begin
            if (out_ready) begin
               outValid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         outPix_q   <= '0;
         outValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         outPix_q   <= outPix_d;
         outValid_q <= outValid_d;
      end
   end

   assign pix_ready = (state_q == MAC);
   assign busy      = (state_q != IDLE);
   assign out_pix   = outPix_q;
   assign out_valid = outValid_q;

endmodule

// File: tb/tb_muladdmem_win.sv
// Directed self-checking bench for muladdmem_win at default parameters.
module tb_muladdmem_win;

   logic        clk, rst_n, we, start, pix_valid, out_ready;
   logic [4:0]  addr, base;
   logic [15:0] dataIn, pix_in, out_pix;
   logic        pix_ready, out_valid, busy;
   logic [15:0] pixVec [9];
   int          passCnt, checkCnt;

   muladdmem_win dut (
      .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .dataIn(dataIn),
      .base(base), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
      .pix_ready(pix_ready), .out_pix(out_pix), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writeW(input logic [4:0] a, input logic [15:0] d);
      we = 1'b1; addr = a; dataIn = d;
      tick();
      we = 1'b0;
   endtask

   task automatic clearWeights();
      for (int i = 0; i < 32; i++) writeW(5'(i), 16'h0000);
   endtask

   // Starts a window, streams pixVec, returns when out_valid rises or the budget expires.
   task automatic runWindow(input logic [4:0] b, input bit bubbles, output logic [15:0] res,
                            output int lat, output bit busyAll, output bit ok);
      int idx;
      bit phase, accepted;
      idx = 0; phase = 1'b1; lat = 0; busyAll = 1'b1; ok = 1'b0; out_ready = 1'b0;
      base = b; start = 1'b1;
      tick();
      start = 1'b0;
      busyAll = busyAll & busy;
      while (lat < 60 && !ok) begin
         if (idx < 9 && (!bubbles || phase)) begin
            pix_valid = 1'b1; pix_in = pixVec[idx];
         end else begin
            pix_valid = 1'b0; pix_in = 16'h0;
         end
         phase = !phase;
         accepted = pix_valid && pix_ready;
         tick();
         lat++;
         if (accepted) idx++;
         busyAll = busyAll & busy;
         if (out_valid) ok = 1'b1;
      end
      pix_valid = 1'b0;
      res = out_pix;
   endtask

   task automatic finishWindow();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checkCnt++; if (pix_ready !== 1'b0) $display("[TB] FAIL reset_pix_ready: got %b expected 0", pix_ready); else passCnt++;
      checkCnt++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passCnt++;
      checkCnt++; if (out_pix !== 16'h0) $display("[TB] FAIL reset_out_pix: got %h expected 0000", out_pix); else passCnt++;
      checkCnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCnt++;
   endtask

   task automatic test_unity();
      logic [15:0] res; int lat; bit busyAll, ok;
      clearWeights();
      for (int i = 0; i < 9; i++) writeW(5'(i), 16'd256);
      for (int i = 0; i < 9; i++) pixVec[i] = 16'(i + 1);
      runWindow(5'd0, 1'b0, res, lat, busyAll, ok);
      checkCnt++; if (ok !== 1'b1) $display("[TB] FAIL unity_timeout: got %b expected 1", ok); else passCnt++;
      checkCnt++; if (res !== 16'd45) $display("[TB] FAIL unity_result: got %0d expected 45", res); else passCnt++;
      checkCnt++; if (lat !== 10) $display("[TB] FAIL unity_latency: got %0d expected 10", lat); else passCnt++;
      checkCnt++; if (busyAll !== 1'b1) $display("[TB] FAIL unity_busy: got %b expected 1", busyAll); else passCnt++;
      finishWindow();
      checkCnt++; if (busy !== 1'b0) $display("[TB] FAIL unity_busy_fall: got %b expected 0", busy); else passCnt++;
      checkCnt++; if (out_valid !== 1'b0) $display("[TB] FAIL unity_valid_fall: got %b expected 0", out_valid); else passCnt++;
   endtask

   task automatic test_saturation();
      logic [15:0] res, expNeg; int lat; bit busyAll, ok;
`ifdef MULADD_RELU_EN
      expNeg = 16'h0000;
`else
      expNeg = 16'h8000;
`endif
      for (int i = 0; i < 9; i++) writeW(5'(i), 16'h7FFF);
      for (int i = 0; i < 9; i++) pixVec[i] = 16'h7FFF;
      runWindow(5'd0, 1'b0, res, lat, busyAll, ok);
      finishWindow();
      checkCnt++; if (res !== 16'h7FFF) $display("[TB] FAIL sat_pos: got %h expected 7fff", res); else passCnt++;
      for (int i = 0; i < 9; i++) pixVec[i] = 16'h8000;
      runWindow(5'd0, 1'b0, res, lat, busyAll, ok);
      finishWindow();
      checkCnt++; if (res !== expNeg) $display("[TB] FAIL sat_neg: got %h expected %h", res, expNeg); else passCnt++;
   endtask

   task automatic test_wrap();
      logic [15:0] res; int lat; bit busyAll, ok;
      clearWeights();
      for (int i = 28; i < 32; i++) writeW(5'(i), 16'd256);
      for (int i = 0; i < 5; i++) writeW(5'(i), 16'd512);
      for (int i = 0; i < 9; i++) pixVec[i] = 16'd1;
      runWindow(5'd28, 1'b0, res, lat, busyAll, ok);
      finishWindow();
      checkCnt++; if (res !== 16'd14) $display("[TB] FAIL wrap_result: got %0d expected 14", res); else passCnt++;
   endtask

   task automatic test_rounding();
      logic [15:0] res; int lat; bit busyAll, ok;
      clearWeights();
      writeW(5'd0, 16'd128);
      for (int i = 0; i < 9; i++) pixVec[i] = 16'd0;
      pixVec[0] = 16'd1;
      runWindow(5'd0, 1'b0, res, lat, busyAll, ok);
      finishWindow();
      checkCnt++; if (res !== 16'd1) $display("[TB] FAIL round_half_up: got %0d expected 1", res); else passCnt++;
      writeW(5'd0, 16'd127);
      runWindow(5'd0, 1'b0, res, lat, busyAll, ok);
      finishWindow();
      checkCnt++; if (res !== 16'd0) $display("[TB] FAIL round_below_half: got %0d expected 0", res); else passCnt++;
   endtask

   task automatic test_backpressure();
      logic [15:0] res; int lat; bit busyAll, ok;
      clearWeights();
      for (int i = 0; i < 9; i++) writeW(5'(i), 16'd256);
      for (int i = 0; i < 9; i++) pixVec[i] = 16'(i + 1);
      runWindow(5'd0, 1'b1, res, lat, busyAll, ok);
      checkCnt++; if (res !== 16'd45) $display("[TB] FAIL bp_result: got %0d expected 45", res); else passCnt++;
      for (int i = 0; i < 5; i++) begin
         checkCnt++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid: got %b expected 1", out_valid); else passCnt++;
         checkCnt++; if (out_pix !== 16'd45) $display("[TB] FAIL bp_hold_pix: got %0d expected 45", out_pix); else passCnt++;
         checkCnt++; if (pix_ready !== 1'b0) $display("[TB] FAIL bp_done_ready: got %b expected 0", pix_ready); else passCnt++;
         start = (i == 2);
         tick();
      end
      start = 1'b0;
      out_ready = 1'b1; start = 1'b1;
      tick();
      out_ready = 1'b0; start = 1'b0;
      checkCnt++; if (busy !== 1'b0) $display("[TB] FAIL bp_idle_after: got %b expected 0", busy); else passCnt++;
      tick();
      checkCnt++; if (busy !== 1'b0) $display("[TB] FAIL bp_start_ignored: got %b expected 0", busy); else passCnt++;
   endtask

   task automatic test_reset_mid();
      logic [15:0] res; int lat; bit busyAll, ok;
      base = 5'd0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pix_valid = 1'b1; pix_in = pixVec[i];
         tick();
      end
      pix_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkCnt++; if (busy !== 1'b0) $display("[TB] FAIL mid_busy: got %b expected 0", busy); else passCnt++;
      checkCnt++; if (pix_ready !== 1'b0) $display("[TB] FAIL mid_pix_ready: got %b expected 0", pix_ready); else passCnt++;
      checkCnt++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_out_valid: got %b expected 0", out_valid); else passCnt++;
      checkCnt++; if (out_pix !== 16'h0) $display("[TB] FAIL mid_out_pix: got %h expected 0000", out_pix); else passCnt++;
      tick();
      rst_n = 1'b1;
      tick();
      runWindow(5'd0, 1'b0, res, lat, busyAll, ok);
      finishWindow();
      checkCnt++; if (res !== 16'd45) $display("[TB] FAIL mid_restart: got %0d expected 45", res); else passCnt++;
   endtask

   initial begin
      passCnt = 0; checkCnt = 0;
      rst_n = 1'b0; we = 1'b0; addr = '0; dataIn = '0; base = '0; start = 1'b0;
      pix_valid = 1'b0; pix_in = '0; out_ready = 1'b0;
      #12;
      test_reset();
      tick();
      rst_n = 1'b1;
      tick();
      test_unity();
      test_saturation();
      test_wrap();
      test_rounding();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
